tape_status_overlay: RTL and testbench

TAPE_STATUS_OVERLAY -- requirements
Module: tape_status_overlay

---
 rtl/tape_overlay_pkg.sv | 39 +++
 rtl/tape_level_meter.sv | 61 ++++++
 rtl/tape_status_overlay.sv | 225 ++++++++++++++++++++++
 tb/tb_tape_status_overlay.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tape_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tape_overlay_pkg
// Description : Shared types and constants for the tape status overlay:
//               write-sequencer states, character codes, meter geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package tape_overlay_pkg;

  // Character-RAM write sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GEAR_L = 2'd1,
    ST_GEAR_R = 2'd2,
    ST_BAR    = 2'd3
  } seq_state_t;

  // Character codes written into VRAM
  localparam logic [7:0] c_chr_gear_a    = 8'h2A;
  localparam logic [7:0] c_chr_gear_b    = 8'h96;
  localparam logic [7:0] c_chr_bar_full  = 8'h7F;
  localparam logic [7:0] c_chr_bar_empty = 8'hA6;

  // Meter fill colour (same value on all three components)
  localparam logic [7:0] c_meter_grey = 8'h80;

  // Overlay geometry, relative to the overlay origin
  localparam int c_box_h_min   = 40;   // exclusive left edge
  localparam int c_box_h_max   = 216;  // exclusive right edge for one channel
  localparam int c_box_v_min   = 8;    // exclusive top edge
  localparam int c_box_v_max   = 96;   // exclusive bottom edge
  localparam int c_ch_pitch    = 12;   // horizontal spacing between channel meters
  localparam int c_meter_x0    = 196;  // left column of channel 0 meter
  localparam int c_meter_w     = 8;    // meter width in pixels
  localparam int c_meter_base  = 88;   // zero-level reference row
  localparam int c_meter_floor = 80;   // exclusive lower limit of the meter fill

endpackage : tape_overlay_pkg
`default_nettype wire

// File: rtl/tape_level_meter.sv
`default_nettype none
// ============================================================================
// Module      : tape_level_meter
// Description : One channel of level/peak tracking, updated once per frame.
//               Level decays by one per frame; peak is held for HOLD frames
//               then decays by one per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_level_meter #(
  parameter int HOLD = 32
) (
  input  logic       i_clk,
  input  logic       reset,
  input  logic       frame_tick_i,
  input  logic [7:0] data_i,
  output logic [5:0] bar_o,
  output logic [5:0] peak_bar_o
);

  localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);

  logic [7:0]    level_q, level_d;
  logic [7:0]    peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [7:0]    w_level_dec;

  // Next frame's level, peak and hold-down counter
  always_comb begin
    w_level_dec = (level_q == 8'd0) ? 8'd0 : level_q - 8'd1;
    level_d     = (data_i > w_level_dec) ? data_i : w_level_dec;
    peak_d      = peak_q;
    hold_d      = hold_q;
    if (data_i >= peak_q) begin
      peak_d = data_i;
      hold_d = HW'(HOLD);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HW'(1);
    end else if (peak_q != 8'd0) begin
      peak_d = peak_q - 8'd1;
    end
  end

  // Meter state advances only on the frame tick
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      level_q <= 8'd0;
      peak_q  <= 8'd0;
      hold_q  <= '0;
    end else if (frame_tick_i) begin
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  // Display uses only the upper six bits (64 rows of resolution)
  assign bar_o      = level_q[7:2];
  assign peak_bar_o = peak_q[7:2];

endmodule : tape_level_meter
`default_nettype wire

// File: rtl/tape_status_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tape_status_overlay
// Description : Tape transport status overlay. Tracks tape position as a
//               segmented progress bar written into character RAM, animates
//               two gear characters, and draws per-channel level meters with
//               peak hold over the incoming video.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_status_overlay
  import tape_overlay_pkg::*;
#(
  parameter logic [23:0] RGB      = 24'hFFFFFF,
  parameter int          SEGS     = 16,
  parameter int          CH       = 2,
  parameter int          X0       = 150,
  parameter int          Y0       = 100,
  parameter int          BAR_ADDR = 136,
  parameter int          GEAR_L   = 331,
  parameter int          GEAR_R   = 340,
  parameter int          HOLD     = 32
) (
  input  logic            i_clk,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic [9:0]      hcnt,
  input  logic [9:0]      vcnt,
  input  logic [7:0]      i_r,
  input  logic [7:0]      i_g,
  input  logic [7:0]      i_b,
  input  logic            ena,
  input  logic [24:0]     max,
  input  logic [24:0]     pos,
  input  logic [CH*8-1:0] tape_data,
  input  logic            chr_a,
  output logic [7:0]      o_r,
  output logic [7:0]      o_g,
  output logic [7:0]      o_b,
  output logic            vram_we,
  output logic [11:0]     vram_addr,
  output logic [7:0]      vram_data
);

  localparam int SH = $clog2(SEGS);   // SEGS is a power of two, >= 2
  localparam int BW = SH + 1;         // block count spans 0..SEGS

  localparam logic [9:0] c_box_h_lim = 10'(c_box_h_max + c_ch_pitch * (CH - 1));

  // ---------------- progress tracking ----------------
  logic [24:0]   pos_q;
  logic [24:0]   inc_q, inc_d;
  logic [BW-1:0] blocks_q, blocks_d;
  logic [24:0]   w_seg_raw, w_seg_len;
  logic          w_pos_chg;

  assign w_seg_raw = max >> SH;
  assign w_seg_len = (w_seg_raw == 25'd0) ? 25'd1 : w_seg_raw;
  assign w_pos_chg = (pos != pos_q);

  // One step of the segment counter per observed position change
  always_comb begin
    inc_d    = inc_q;
    blocks_d = blocks_q;
    if (w_pos_chg) begin
      if (pos == 25'd0) begin
        inc_d    = 25'd0;
        blocks_d = '0;
      end else if (pos > pos_q) begin
        // >= guards against a shrinking max leaving inc beyond the segment
        if (inc_q >= w_seg_len - 25'd1) begin
          inc_d = 25'd0;
          if (blocks_q != BW'(SEGS)) blocks_d = blocks_q + BW'(1);
        end else begin
          inc_d = inc_q + 25'd1;
        end
      end else begin
        if (inc_q == 25'd0) begin
          inc_d = w_seg_len - 25'd1;
          if (blocks_q != '0) blocks_d = blocks_q - BW'(1);
        end else begin
          inc_d = inc_q - 25'd1;
        end
      end
    end
  end

  // ---------------- VRAM write sequencer ----------------
  seq_state_t    state_q, state_d;
  logic [SH-1:0] k_q, k_d;
  logic          phase_q, phase_d;
  logic          pending_q, pending_d;

  // Sequencer next state; write port is decoded from the current state
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    phase_d   = phase_q;
    pending_d = pending_q | w_pos_chg;
    vram_we   = 1'b0;
    vram_addr = 12'd0;
    vram_data = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_GEAR_L;
          pending_d = w_pos_chg;   // a change in this very cycle queues a rerun
        end
      end
      ST_GEAR_L: begin
        vram_we   = 1'b1;
        vram_addr = 12'(GEAR_L);
        vram_data = phase_q ? c_chr_gear_a : c_chr_gear_b;
        state_d   = ST_GEAR_R;
      end
      ST_GEAR_R: begin
        vram_we   = 1'b1;
        vram_addr = 12'(GEAR_R);
        vram_data = phase_q ? c_chr_gear_b : c_chr_gear_a;
        phase_d   = ~phase_q;
        k_d       = '0;
        state_d   = ST_BAR;
      end
      ST_BAR: begin
        vram_we   = 1'b1;
        vram_addr = 12'(BAR_ADDR) + 12'(k_q);
        vram_data = ({1'b0, k_q} < blocks_q) ? c_chr_bar_full : c_chr_bar_empty;
        if (k_q == SH'(SEGS - 1)) state_d = ST_IDLE;
        else                      k_d     = k_q + SH'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Progress counters and sequencer registers
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset) begin
      pos_q     <= 25'd0;
      inc_q     <= 25'd0;
      blocks_q  <= '0;
      state_q   <= ST_IDLE;
      k_q       <= '0;
      phase_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pos_q     <= pos;
      inc_q     <= inc_d;
      blocks_q  <= blocks_d;
      state_q   <= state_d;
      k_q       <= k_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
    end
  end

  // ---------------- level meters ----------------
  logic       origin_seen_q;
  logic       w_origin, w_frame_tick;
  logic [9:0] w_nh, w_nv;
  logic [5:0] w_bar  [CH];
  logic [5:0] w_peak [CH];
  logic [CH-1:0] w_meter_hit, w_peak_hit;

  assign w_origin     = (hcnt == 10'd0) && (vcnt == 10'd0);
  assign w_frame_tick = ce_pix && w_origin && !origin_seen_q;
  assign w_nh         = hcnt - 10'(X0);
  assign w_nv         = vcnt - 10'(Y0);

  // Remember that the origin pixel was seen so the frame tick fires once
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset)       origin_seen_q <= 1'b0;
    else if (ce_pix) origin_seen_q <= w_origin;
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam logic [9:0] c_xl = 10'(c_meter_x0 + c_ch_pitch * c);
    localparam logic [9:0] c_xr = 10'(c_meter_x0 + c_meter_w + c_ch_pitch * c);
    logic w_col;

    tape_level_meter #(
      .HOLD (HOLD)
    ) u_meter (
      .i_clk        (i_clk),
      .reset        (reset),
      .frame_tick_i (w_frame_tick),
      .data_i       (tape_data[8*c +: 8]),
      .bar_o        (w_bar[c]),
      .peak_bar_o   (w_peak[c])
    );

    assign w_col          = (w_nh >= c_xl) && (w_nh < c_xr);
    assign w_meter_hit[c] = w_col && (w_nv > 10'(c_meter_base) - {4'b0, w_bar[c]})
                                  && (w_nv < 10'(c_meter_floor));
    assign w_peak_hit[c]  = w_col && (w_nv == 10'(c_meter_base) - {4'b0, w_peak[c]});
  end

  // ---------------- compositing ----------------
  logic        w_in_box;
  logic [23:0] pix_d, pix_q;

  assign w_in_box = (w_nh > 10'(c_box_h_min)) && (w_nh < c_box_h_lim)
                 && (w_nv > 10'(c_box_v_min)) && (w_nv < 10'(c_box_v_max));

  // Pixel priority: peak line, meter fill, text, then dimmed background
  always_comb begin
    pix_d = {i_r, i_g, i_b};
    if (ena && w_in_box) begin
      if (|w_peak_hit)       pix_d = RGB;
      else if (|w_meter_hit) pix_d = {3{c_meter_grey}};
      else if (chr_a)        pix_d = RGB;
      else                   pix_d = {i_r >> 2, i_g >> 2, i_b >> 2};
    end
  end

  // One pixel-enable of latency in both overlay and passthrough paths
  always_ff @(posedge i_clk or posedge reset) begin
    if (reset)       pix_q <= 24'd0;
    else if (ce_pix) pix_q <= pix_d;
  end

  assign o_r = pix_q[23:16];
  assign o_g = pix_q[15:8];
  assign o_b = pix_q[7:0];

endmodule : tape_status_overlay
`default_nettype wire

// File: tb/tb_tape_status_overlay.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_status_overlay
// Description : Directed self-checking bench for tape_status_overlay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_status_overlay;
  import tape_overlay_pkg::*;

  logic        i_clk = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic [9:0]  hcnt, vcnt;
  logic [7:0]  i_r, i_g, i_b;
  logic        ena;
  logic [24:0] tb_max, tb_pos;
  logic [15:0] tape_data;
  logic        chr_a;
  logic [7:0]  o_r, o_g, o_b;
  logic        vram_we;
  logic [11:0] vram_addr;
  logic [7:0]  vram_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] wr_addr [$];
  logic [7:0]  wr_data [$];

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        en;
    logic        ca;
    logic [23:0] vin;
    logic [23:0] vexp;
  } pix_t;

  tape_status_overlay dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .hcnt      (hcnt),
    .vcnt      (vcnt),
    .i_r       (i_r),
    .i_g       (i_g),
    .i_b       (i_b),
    .ena       (ena),
    .max       (tb_max),
    .pos       (tb_pos),
    .tape_data (tape_data),
    .chr_a     (chr_a),
    .o_r       (o_r),
    .o_g       (o_g),
    .o_b       (o_b),
    .vram_we   (vram_we),
    .vram_addr (vram_addr),
    .vram_data (vram_data)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (vram_we === 1'b1) begin
      wr_addr.push_back(vram_addr);
      wr_data.push_back(vram_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge i_clk);
    reset  = 1'b1;
    tb_pos = 25'd0;
    repeat (2) @(negedge i_clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic wait_idle(input string nm);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 3000) begin
      @(negedge i_clk);
      n++;
      if (vram_we === 1'b1) quiet = 0;
      else                  quiet++;
    end
    n_tests++;
    if (quiet < 3) begin
      n_fail++;
      $display("FAIL %s idle: sequencer still writing after %0d cycles, required idle", nm, n);
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({o_r, o_g, o_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_video: got %h, required 000000", {o_r, o_g, o_b});
    end
    n_tests++;
    if ({vram_we, vram_addr, vram_data} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_vram: we=%b addr=%h data=%h, required all 0", vram_we, vram_addr, vram_data);
    end
    ce_pix = 1'b1;
    repeat (2) @(negedge i_clk);
    n_tests++;
    if ({o_r, o_g, o_b} !== 24'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h, required 000000", {o_r, o_g, o_b});
    end
    ce_pix = 1'b0;
    reset  = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] gl, gr;
    int b;
    do_reset();
    @(negedge i_clk); tb_pos = 25'd5;
    @(negedge i_clk); tb_pos = 25'd6;
    wait_idle("b2b");
    n_tests++;
    if (wr_addr.size() != 36) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d writes, required 36", wr_addr.size());
    end else begin
      for (int s = 0; s < 2; s++) begin
        b  = s * 18;
        gl = (s == 0) ? 8'h96 : 8'h2A;
        gr = (s == 0) ? 8'h2A : 8'h96;
        n_tests++;
        if (wr_addr[b] !== 12'd331 || wr_data[b] !== gl ||
            wr_addr[b+1] !== 12'd340 || wr_data[b+1] !== gr) begin
          n_fail++;
          $display("FAIL b2b_gear%0d: got %h:%h %h:%h, required 14b:%h 154:%h",
                   s, wr_addr[b], wr_data[b], wr_addr[b+1], wr_data[b+1], gl, gr);
        end
        for (int k = 0; k < 16; k++) begin
          n_tests++;
          if (wr_addr[b+2+k] !== 12'(136 + k) || wr_data[b+2+k] !== 8'hA6) begin
            n_fail++;
            $display("FAIL b2b_bar%0d_%0d: got %h:%h, required %h:a6",
                     s, k, wr_addr[b+2+k], wr_data[b+2+k], 12'(136 + k));
          end
        end
      end
    end
  endtask

  task automatic test_bar_up();
    int n;
    logic [7:0] e;
    do_reset();
    tb_max = 25'd1600;
    for (int p = 0; p < 300; p++) begin
      @(negedge i_clk);
      tb_pos = tb_pos + 25'd1;
    end
    wait_idle("bar_up");
    n_tests++;
    if (dut.blocks_q !== 5'd3 || dut.inc_q !== 25'd0) begin
      n_fail++;
      $display("FAIL bar_up_count: blocks=%0d inc=%0d, required 3 and 0", dut.blocks_q, dut.inc_q);
    end
    n = wr_addr.size();
    n_tests++;
    if (n < 18) begin
      n_fail++;
      $display("FAIL bar_up_writes: got %0d writes, required at least 18", n);
    end else begin
      for (int k = 0; k < 16; k++) begin
        e = (k < 3) ? 8'h7F : 8'hA6;
        n_tests++;
        if (wr_addr[n-16+k] !== 12'(136 + k) || wr_data[n-16+k] !== e) begin
          n_fail++;
          $display("FAIL bar_up_%0d: got %h:%h, required %h:%h",
                   k, wr_addr[n-16+k], wr_data[n-16+k], 12'(136 + k), e);
        end
      end
    end
  endtask

  task automatic test_bar_down();
    int n;
    logic [7:0] e;
    wr_addr.delete();
    wr_data.delete();
    for (int p = 0; p < 100; p++) begin
      @(negedge i_clk);
      tb_pos = tb_pos - 25'd1;
    end
    wait_idle("bar_down");
    n_tests++;
    if (dut.blocks_q !== 5'd2 || dut.inc_q !== 25'd0) begin
      n_fail++;
      $display("FAIL bar_down_count: blocks=%0d inc=%0d, required 2 and 0", dut.blocks_q, dut.inc_q);
    end
    n = wr_addr.size();
    n_tests++;
    if (n < 18) begin
      n_fail++;
      $display("FAIL bar_down_writes: got %0d writes, required at least 18", n);
    end else begin
      for (int k = 0; k < 16; k++) begin
        e = (k < 2) ? 8'h7F : 8'hA6;
        n_tests++;
        if (wr_data[n-16+k] !== e) begin
          n_fail++;
          $display("FAIL bar_down_%0d: got %h, required %h", k, wr_data[n-16+k], e);
        end
      end
    end
    wr_addr.delete();
    wr_data.delete();
    @(negedge i_clk); tb_pos = 25'd0;
    wait_idle("bar_zero");
    n_tests++;
    if (dut.blocks_q !== 5'd0 || dut.inc_q !== 25'd0 || wr_addr.size() != 18) begin
      n_fail++;
      $display("FAIL bar_zero_count: blocks=%0d inc=%0d writes=%0d, required 0 0 18",
               dut.blocks_q, dut.inc_q, wr_addr.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_tests++;
        if (wr_data[2+k] !== 8'hA6) begin
          n_fail++;
          $display("FAIL bar_zero_%0d: got %h, required a6", k, wr_data[2+k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_bar();
    int n = 0;
    bit hit = 0;
    do_reset();
    @(negedge i_clk); tb_pos = 25'd7;
    while (!hit && n < 100) begin
      @(negedge i_clk);
      n++;
      if (vram_we === 1'b1 && vram_addr === 12'd141) hit = 1;
    end
    n_tests++;
    if (!hit) begin
      n_fail++;
      $display("FAIL midbar_reach: bar slot 5 not written within %0d cycles, required a write", n);
    end
    reset  = 1'b1;
    tb_pos = 25'd0;
    #1;
    n_tests++;
    if (vram_we !== 1'b0 || dut.state_q !== ST_IDLE) begin
      n_fail++;
      $display("FAIL midbar_abort: we=%b state=%0d, required 0 and IDLE", vram_we, dut.state_q);
    end
    @(posedge i_clk); #1;
    n_tests++;
    if (vram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL midbar_edge: we=%b, required 0", vram_we);
    end
    @(negedge i_clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    repeat (30) @(negedge i_clk);
    n_tests++;
    if (wr_addr.size() != 0) begin
      n_fail++;
      $display("FAIL midbar_quiet: got %0d writes, required 0", wr_addr.size());
    end
    tb_pos = 25'd9;
    wait_idle("midbar_restart");
    n_tests++;
    if (wr_addr.size() != 18 || wr_addr[0] !== 12'd331 || wr_data[0] !== 8'h96) begin
      n_fail++;
      $display("FAIL midbar_restart: writes=%0d first=%h:%h, required 18 writes first 14b:96",
               wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 12'h0,
               wr_data.size() > 0 ? wr_data[0] : 8'h0);
    end
  endtask

  task automatic test_meter();
    logic [7:0] el, ep;
    @(negedge i_clk);
    ce_pix = 1'b1; hcnt = 10'd0; vcnt = 10'd0; tape_data = 16'h00C8;
    @(negedge i_clk);
    hcnt = 10'd1; tape_data = 16'h0000;
    @(negedge i_clk);
    n_tests++;
    if (dut.g_ch[0].u_meter.level_q !== 8'd200 || dut.g_ch[0].u_meter.peak_q !== 8'd200) begin
      n_fail++;
      $display("FAIL meter_f0: level=%0d peak=%0d, required 200 200",
               dut.g_ch[0].u_meter.level_q, dut.g_ch[0].u_meter.peak_q);
    end
    for (int f = 1; f <= 34; f++) begin
      hcnt = 10'd0;
      repeat (2) @(negedge i_clk);   // origin held for two pixels: one tick only
      hcnt = 10'd1;
      @(negedge i_clk);
      el = 8'(200 - f);
      ep = (f <= 32) ? 8'd200 : 8'(200 - (f - 32));
      if (f <= 3 || f >= 31) begin
        n_tests++;
        if (dut.g_ch[0].u_meter.level_q !== el || dut.g_ch[0].u_meter.peak_q !== ep) begin
          n_fail++;
          $display("FAIL meter_f%0d: level=%0d peak=%0d, required %0d %0d", f,
                   dut.g_ch[0].u_meter.level_q, dut.g_ch[0].u_meter.peak_q, el, ep);
        end
      end
    end
    n_tests++;
    if (dut.g_ch[1].u_meter.level_q !== 8'd0 || dut.g_ch[1].u_meter.peak_q !== 8'd0) begin
      n_fail++;
      $display("FAIL meter_ch1: level=%0d peak=%0d, required 0 0",
               dut.g_ch[1].u_meter.level_q, dut.g_ch[1].u_meter.peak_q);
    end
    ce_pix = 1'b0;
  endtask

  task automatic test_video();
    pix_t vecs [0:17];
    // Channel 0: level 166 (fill rows 48..79), peak 198 (row 39); channel 1 at 0 (peak row 88)
    vecs[0]  = {10'd250, 10'd150, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[1]  = {10'd250, 10'd150, 1'b1, 1'b1, 24'hFF8040, 24'hFFFFFF};
    vecs[2]  = {10'd250, 10'd150, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040};
    vecs[3]  = {10'd190, 10'd150, 1'b1, 1'b1, 24'hFF8040, 24'hFF8040};
    vecs[4]  = {10'd191, 10'd150, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[5]  = {10'd250, 10'd108, 1'b1, 1'b0, 24'hFF8040, 24'hFF8040};
    vecs[6]  = {10'd250, 10'd109, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[7]  = {10'd348, 10'd160, 1'b1, 1'b1, 24'hFF8040, 24'h808080};
    vecs[8]  = {10'd348, 10'd139, 1'b1, 1'b0, 24'hFF8040, 24'hFFFFFF};
    vecs[9]  = {10'd348, 10'd147, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[10] = {10'd348, 10'd148, 1'b1, 1'b0, 24'hFF8040, 24'h808080};
    vecs[11] = {10'd348, 10'd180, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[12] = {10'd360, 10'd188, 1'b1, 1'b0, 24'hFF8040, 24'hFFFFFF};
    vecs[13] = {10'd360, 10'd187, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[14] = {10'd377, 10'd150, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};
    vecs[15] = {10'd378, 10'd150, 1'b1, 1'b0, 24'hFF8040, 24'hFF8040};
    vecs[16] = {10'd346, 10'd160, 1'b1, 1'b0, 24'hFF8040, 24'h808080};
    vecs[17] = {10'd354, 10'd160, 1'b1, 1'b0, 24'hFF8040, 24'h3F2010};

    // Passthrough latency and hold while ce_pix is low
    @(negedge i_clk);
    ena = 1'b0; ce_pix = 1'b1; hcnt = 10'd250; vcnt = 10'd150;
    {i_r, i_g, i_b} = 24'h123456;
    @(negedge i_clk);
    n_tests++;
    if ({o_r, o_g, o_b} !== 24'h123456) begin
      n_fail++;
      $display("FAIL pass_latency: got %h, required 123456", {o_r, o_g, o_b});
    end
    ce_pix = 1'b0; {i_r, i_g, i_b} = 24'hABCDEF;
    @(negedge i_clk);
    n_tests++;
    if ({o_r, o_g, o_b} !== 24'h123456) begin
      n_fail++;
      $display("FAIL pass_hold: got %h, required 123456", {o_r, o_g, o_b});
    end
    ce_pix = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if ({o_r, o_g, o_b} !== 24'hABCDEF) begin
      n_fail++;
      $display("FAIL pass_next: got %h, required abcdef", {o_r, o_g, o_b});
    end

    for (int i = 0; i < 18; i++) begin
      hcnt = vecs[i].h; vcnt = vecs[i].v; ena = vecs[i].en; chr_a = vecs[i].ca;
      {i_r, i_g, i_b} = vecs[i].vin;
      @(negedge i_clk);
      n_tests++;
      if ({o_r, o_g, o_b} !== vecs[i].vexp) begin
        n_fail++;
        $display("FAIL pixel_%0d: h=%0d v=%0d got %h, required %h",
                 i, vecs[i].h, vecs[i].v, {o_r, o_g, o_b}, vecs[i].vexp);
      end
    end
    ce_pix = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce_pix = 1'b0; hcnt = 10'd5; vcnt = 10'd5;
    i_r = 8'h11; i_g = 8'h22; i_b = 8'h33; ena = 1'b0; chr_a = 1'b0;
    tb_max = 25'd1600; tb_pos = 25'd0; tape_data = 16'h0000;

    test_reset();
    test_back_to_back();
    test_bar_up();
    test_bar_down();
    test_reset_mid_bar();
    test_meter();
    test_video();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_tape_status_overlay
`default_nettype wire
